// File: rtl/board_pkg.sv
// Shared board geometry and helpers for the board state latch.
package board_pkg;

    localparam int unsigned NUM_CELLS = 9;
    localparam int unsigned CELL_W    = 4;
    localparam logic [CELL_W-1:0] CELL_NONE = 4'd0;

    // Cell number 1..NUM_CELLS of the single set bit, CELL_NONE if not one-hot.
    function automatic logic [CELL_W-1:0] onehot_index(input logic [NUM_CELLS-1:0] v);
        logic [CELL_W-1:0] idx;
        int unsigned       ones;
        idx  = CELL_NONE;
        ones = 0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (v[i]) begin
                ones = ones + 1;
                idx  = CELL_W'(i + 1);
            end
        end
        return (ones == 1) ? idx : CELL_NONE;
    endfunction

endpackage

// File: rtl/vsync_tick.sv
// Synchronises the LCD frame sync and turns its rising edge into a one-cycle frame tick.
module vsync_tick (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic vsync,
    output logic tick
);

    // sync[1:0] is the two-flop synchroniser, sync[2] holds the previous synchronised level
    logic [2:0] sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= 3'b000;
            tick <= 1'b0;
        end else begin
            sync <= {sync[1:0], vsync};
            tick <= enable & sync[1] & ~sync[2];
        end
    end

endmodule

// File: rtl/board_state_latch.sv
// Debounces per-cell occupancy across frames, commits a stable board image and
// reports each newly placed piece as a single-cell move over valid/ready.
module board_state_latch
    import board_pkg::*;
#(
    parameter int unsigned STABLE_FRAMES = 4,
    parameter int unsigned CNT_W         = 4
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 sys_init_done,
    input  logic                 out_vsync,
    input  logic [NUM_CELLS-1:0] full_detect,
    input  logic                 board_clear,
    output logic [NUM_CELLS-1:0] full_store,
    output logic                 move_valid,
    output logic [CELL_W-1:0]    move_cell,
    input  logic                 move_ready,
    output logic                 board_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_FRAMES);

    logic                 frame_tick;
    logic                 eval_pending;
    logic [NUM_CELLS-1:0] prev_sample;
    logic [CNT_W-1:0]     stable_cnt;

    logic                 eval_pending_d;
    logic [NUM_CELLS-1:0] prev_sample_d;
    logic [CNT_W-1:0]     stable_cnt_d;
    logic [NUM_CELLS-1:0] full_store_d;
    logic                 move_valid_d;
    logic [CELL_W-1:0]    move_cell_d;
    logic                 board_err_d;

    logic [NUM_CELLS-1:0] diff_c;
    logic [CELL_W-1:0]    diff_cell_c;
    logic                 piece_added_c;
    logic                 commit_c;

    vsync_tick u_vsync_tick (
        .clk    (sys_clk),
        .rst    (sys_rst),
        .enable (sys_init_done),
        .vsync  (out_vsync),
        .tick   (frame_tick)
    );

    // A single new bit that is present in the sample is a legal placement.
    assign diff_c        = prev_sample ^ full_store;
    assign diff_cell_c   = onehot_index(diff_c);
    assign piece_added_c = (diff_cell_c != CELL_NONE) && ((diff_c & prev_sample) == diff_c);
    assign commit_c      = eval_pending && (stable_cnt == CNT_MAX) &&
                           (prev_sample != full_store) && !move_valid;

    // Next-state: sampling, commit, handshake, then board_clear overriding all.
    always_comb begin
        eval_pending_d = frame_tick;
        prev_sample_d  = prev_sample;
        stable_cnt_d   = stable_cnt;
        full_store_d   = full_store;
        move_valid_d   = move_valid;
        move_cell_d    = move_cell;
        board_err_d    = board_err;

        if (frame_tick) begin
            if (full_detect == prev_sample) begin
                if (stable_cnt < CNT_MAX) begin
                    stable_cnt_d = stable_cnt + CNT_W'(1);
                end
            end else begin
                prev_sample_d = full_detect;
                stable_cnt_d  = CNT_W'(1);
            end
        end

        if (commit_c) begin
            if (piece_added_c) begin
                full_store_d = prev_sample;
                move_valid_d = 1'b1;
                move_cell_d  = diff_cell_c;
            end else begin
                board_err_d = 1'b1;
            end
        end

        if (move_valid && move_ready) begin
            move_valid_d = 1'b0;
            move_cell_d  = CELL_NONE;
        end

        if (board_clear) begin
            eval_pending_d = 1'b0;
            prev_sample_d  = '0;
            stable_cnt_d   = '0;
            full_store_d   = '0;
            move_valid_d   = 1'b0;
            move_cell_d    = CELL_NONE;
            board_err_d    = 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            eval_pending <= 1'b0;
            prev_sample  <= '0;
            stable_cnt   <= '0;
            full_store   <= '0;
            move_valid   <= 1'b0;
            move_cell    <= CELL_NONE;
            board_err    <= 1'b0;
        end else begin
            eval_pending <= eval_pending_d;
            prev_sample  <= prev_sample_d;
            stable_cnt   <= stable_cnt_d;
            full_store   <= full_store_d;
            move_valid   <= move_valid_d;
            move_cell    <= move_cell_d;
            board_err    <= board_err_d;
        end
    end

endmodule

// File: tb/tb_board_state_latch.sv
// Frame-level self-checking bench for board_state_latch against a behavioural board model.
module tb_board_state_latch;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       sys_init_done = 1'b0;
    logic       out_vsync = 1'b0;
    logic [8:0] full_detect = '0;
    logic       board_clear = 1'b0;
    logic [8:0] full_store;
    logic       move_valid;
    logic [3:0] move_cell;
    logic       move_ready = 1'b0;
    logic       board_err;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model state (frame granularity)
    logic [8:0] m_prev, m_store;
    int         m_cnt;
    logic       m_valid, m_err;
    logic [3:0] m_cell;

    logic [14:0] got, exp;

    board_state_latch #(.STABLE_FRAMES(4), .CNT_W(4)) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .sys_init_done (sys_init_done),
        .out_vsync     (out_vsync),
        .full_detect   (full_detect),
        .board_clear   (board_clear),
        .full_store    (full_store),
        .move_valid    (move_valid),
        .move_cell     (move_cell),
        .move_ready    (move_ready),
        .board_err     (board_err)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic void model_clear();
        m_prev = '0; m_store = '0; m_cnt = 0;
        m_valid = 1'b0; m_cell = 4'd0; m_err = 1'b0;
    endfunction

    // One counted frame: debounce, then judge the stable image against the board.
    function automatic void model_frame(input logic [8:0] det);
        logic [8:0] d;
        if (det == m_prev) m_cnt = (m_cnt + 1 > 4) ? 4 : m_cnt + 1;
        else begin m_prev = det; m_cnt = 1; end
        d = m_prev ^ m_store;
        if (m_cnt == 4 && d != 0 && !m_valid) begin
            if ($countones(d) == 1 && (d & m_prev) != 0) begin
                m_store = m_prev;
                m_valid = 1'b1;
                m_cell  = 4'($clog2(d) + 1);
            end else begin
                m_err = 1'b1;
            end
        end
    endfunction

    // Drive one vsync pulse with the given detect pattern and let the block settle.
    task automatic run_frame(input logic [8:0] det, input logic clr);
        @(negedge sys_clk);
        full_detect = det;
        board_clear = clr;
        out_vsync = 1'b1;
        repeat (4) @(negedge sys_clk);
        out_vsync = 1'b0;
        repeat (6) @(negedge sys_clk);
        board_clear = 1'b0;
        if (clr) model_clear();
        else if (sys_init_done) model_frame(det);
    endtask

    task automatic accept();
        @(negedge sys_clk);
        move_ready = 1'b1;
        @(negedge sys_clk);
        move_ready = 1'b0;
        if (m_valid) begin m_valid = 1'b0; m_cell = 4'd0; end
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst = 1'b1;
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        sys_init_done = 1'b0;
        do_reset();
        got = {full_store, move_valid, move_cell, board_err};
        exp = 15'd0;
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL reset: got %h expected %h", got, exp);
        end
        sys_init_done = 1'b1;
    endtask

    task automatic test_debounce_commit();
        for (int f = 0; f < 4; f++) begin
            run_frame(9'h010, 1'b0);
            got = {full_store, move_valid, move_cell, board_err};
            exp = {m_store, m_valid, m_cell, m_err};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL debounce frame %0d: got %h expected %h", f, got, exp);
            end
        end
        vectors++;
        if ({full_store, move_valid, move_cell} !== {9'h010, 1'b1, 4'd5}) begin
            miscompares++;
            $display("FAIL commit_cell5: got store=%h v=%b cell=%0d expected 010/1/5",
                     full_store, move_valid, move_cell);
        end
    endtask

    task automatic test_glitch();
        logic [8:0] seq [8];
        do_reset();
        seq = '{9'h001, 9'h001, 9'h001, 9'h000, 9'h001, 9'h001, 9'h001, 9'h001};
        for (int f = 0; f < 8; f++) begin
            run_frame(seq[f], 1'b0);
            got = {full_store, move_valid, move_cell, board_err};
            exp = {m_store, m_valid, m_cell, m_err};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL glitch frame %0d: got %h expected %h", f, got, exp);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        repeat (4) run_frame(9'h010, 1'b0);
        for (int f = 0; f < 6; f++) begin
            run_frame(9'h110, 1'b0);
            got = {full_store, move_valid, move_cell, board_err};
            exp = {m_store, m_valid, m_cell, m_err};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL backpressure frame %0d: got %h expected %h", f, got, exp);
            end
        end
        accept();
        got = {full_store, move_valid, move_cell, board_err};
        exp = {9'h010, 1'b0, 4'd0, 1'b0};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL backpressure accept: got %h expected %h", got, exp);
        end
        run_frame(9'h110, 1'b0);
        got = {full_store, move_valid, move_cell, board_err};
        exp = {9'h110, 1'b1, 4'd9, 1'b0};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL deferred commit: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        repeat (4) run_frame(9'h010, 1'b0);
        accept();
        repeat (4) run_frame(9'h003, 1'b0);
        got = {full_store, move_valid, move_cell, board_err};
        exp = {9'h010, 1'b0, 4'd0, 1'b1};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL illegal change: got %h expected %h", got, exp);
        end
        repeat (2) run_frame(9'h003, 1'b0);
        got = {full_store, move_valid, move_cell, board_err};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL illegal sticky: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_clear_priority();
        repeat (3) run_frame(9'h030, 1'b0);
        run_frame(9'h030, 1'b1);
        got = {full_store, move_valid, move_cell, board_err};
        exp = 15'd0;
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL clear priority: got %h expected %h", got, exp);
        end
        for (int f = 0; f < 4; f++) begin
            run_frame(9'h020, 1'b0);
            got = {full_store, move_valid, move_cell, board_err};
            exp = {m_store, m_valid, m_cell, m_err};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL clear restart frame %0d: got %h expected %h", f, got, exp);
            end
        end
    endtask

    task automatic test_reset_mid_handshake();
        // Board is cell 6 pending from the previous scenario.
        @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        model_clear();
        got = {full_store, move_valid, move_cell, board_err};
        exp = 15'd0;
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL reset mid-handshake: got %h expected %h", got, exp);
        end
        sys_init_done = 1'b0;
        repeat (5) run_frame(9'h001, 1'b0);
        sys_init_done = 1'b1;
        for (int f = 0; f < 4; f++) begin
            run_frame(9'h001, 1'b0);
            got = {full_store, move_valid, move_cell, board_err};
            exp = {m_store, m_valid, m_cell, m_err};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL init gating frame %0d: got %h expected %h", f, got, exp);
            end
        end
    endtask

    task automatic test_random();
        logic [8:0] cur;
        int         r;
        logic       clr;
        do_reset();
        sys_init_done = 1'b1;
        cur = '0;
        for (int f = 0; f < 200; f++) begin
            r = $urandom_range(0, 9);
            if (r == 6 || r == 7) cur[$urandom_range(0, 8)] = 1'b1;
            else if (r == 8) cur = 9'($urandom);
            else if (r == 9) cur = cur & 9'($urandom);
            clr = ($urandom_range(0, 29) == 0);
            if (clr) cur = '0;
            if ($urandom_range(0, 14) == 0) sys_init_done = ~sys_init_done;
            run_frame(cur, clr);
            if ($urandom_range(0, 2) == 0) accept();
            got = {full_store, move_valid, move_cell, board_err};
            exp = {m_store, m_valid, m_cell, m_err};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL random frame %0d det=%h: got %h expected %h", f, cur, got, exp);
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_debounce_commit();
        test_glitch();
        test_backpressure();
        test_illegal();
        test_clear_priority();
        test_reset_mid_handshake();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
